mem_bus_arbiter: RTL and testbench



---
 rtl/mem_bus_arbiter_pkg.sv | 35 +++
 rtl/mem_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory bus arbiter: one-hot state encodings,
// bus transfer size codes and the latched bus command record.
package mem_bus_arbiter_pkg;

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    I_ADDR = 5'b00010,
    I_WAIT = 5'b00100,
    D_ADDR = 5'b01000,
    D_WAIT = 5'b10000
  } arb_state_e;

  // Size codes are shared with the cache/AXI bridge side of the bus.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_cmd_t;

  // Instruction fetches are always full-word reads.
  function automatic bus_cmd_t fetch_cmd(input logic [31:0] addr);
    bus_cmd_t cmd;
    cmd.wr    = 1'b0;
    cmd.size  = SZ_WORD;
    cmd.addr  = addr;
    cmd.wdata = 32'h0;
    return cmd;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Serialises IF and MEM requests onto one SRAM-like bus, one transaction at a time.
// Data has priority; a run counter forces an instruction grant after MAX_DATA_RUN data grants.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DATA_RUN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_done,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_done,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        mem_stall,
  output logic        mem_done
);

  localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);

  arb_state_e  state_reg;
  logic [3:0]  run_cnt_reg;
  logic [3:0]  run_cnt_next;
  logic        discard_reg;
  logic        bus_req_reg;
  bus_cmd_t    cmd_reg;
  bus_cmd_t    data_cmd;
  logic [31:0] inst_rdata_reg;
  logic [31:0] data_rdata_reg;
  logic        inst_done_reg;
  logic        data_done_reg;

  logic inst_pending;
  logic inst_take;
  logic data_take;
  logic grant_inst;
  logic grant_data;

  // A requester whose done is high this cycle has its request treated as consumed.
  always_comb begin
    inst_pending = inst_req & ~inst_done_reg;
    inst_take    = inst_pending & ~flush;
    data_take    = data_req & ~data_done_reg;
    grant_inst   = (state_reg == IDLE) & inst_take
                 & (~data_take | (run_cnt_reg == RUN_MAX));
    grant_data   = (state_reg == IDLE) & data_take & ~grant_inst;

    data_cmd.wr    = data_wr;
    data_cmd.size  = data_size;
    data_cmd.addr  = data_addr;
    data_cmd.wdata = data_wdata;

    run_cnt_next = run_cnt_reg;
    if (grant_inst) begin
      run_cnt_next = 4'd0;
    end else if (grant_data) begin
      if (!inst_pending) begin
        run_cnt_next = 4'd0;
      end else if (run_cnt_reg != RUN_MAX) begin
        run_cnt_next = run_cnt_reg + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      run_cnt_reg    <= 4'd0;
      discard_reg    <= 1'b0;
      bus_req_reg    <= 1'b0;
      cmd_reg        <= '0;
      inst_rdata_reg <= 32'h0;
      data_rdata_reg <= 32'h0;
      inst_done_reg  <= 1'b0;
      data_done_reg  <= 1'b0;
    end else begin
      inst_done_reg <= 1'b0;
      data_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          run_cnt_reg <= run_cnt_next;
          if (grant_data) begin
            bus_req_reg <= 1'b1;
            cmd_reg     <= data_cmd;
            state_reg   <= D_ADDR;
          end else if (grant_inst) begin
            bus_req_reg <= 1'b1;
            cmd_reg     <= fetch_cmd(inst_addr);
            state_reg   <= I_ADDR;
          end
        end
        I_ADDR: begin
          if (flush) begin
            discard_reg <= 1'b1;
          end
          if (bus_addr_ok) begin
            bus_req_reg <= 1'b0;
            state_reg   <= I_WAIT;
          end
        end
        I_WAIT: begin
          // A flushed fetch still drains the bus but never reaches the IF stage.
          if (bus_data_ok) begin
            if (!(discard_reg || flush)) begin
              inst_rdata_reg <= bus_rdata;
              inst_done_reg  <= 1'b1;
            end
            discard_reg <= 1'b0;
            state_reg   <= IDLE;
          end else if (flush) begin
            discard_reg <= 1'b1;
          end
        end
        D_ADDR: begin
          if (bus_addr_ok) begin
            bus_req_reg <= 1'b0;
            state_reg   <= D_WAIT;
          end
        end
        D_WAIT: begin
          if (bus_data_ok) begin
            data_rdata_reg <= bus_rdata;
            data_done_reg  <= 1'b1;
            state_reg      <= IDLE;
          end
        end
        default: begin
          bus_req_reg <= 1'b0;
          discard_reg <= 1'b0;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

  assign bus_req    = bus_req_reg;
  assign bus_wr     = cmd_reg.wr;
  assign bus_size   = cmd_reg.size;
  assign bus_addr   = cmd_reg.addr;
  assign bus_wdata  = cmd_reg.wdata;
  assign inst_rdata = inst_rdata_reg;
  assign data_rdata = data_rdata_reg;
  assign inst_done  = inst_done_reg;
  assign data_done  = data_done_reg;
  assign mem_done   = inst_done_reg | data_done_reg;
  assign mem_stall  = (inst_req & ~inst_done_reg) | (data_req & ~data_done_reg);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed requests push expected bus commands and
// completions into queues; independent monitors pop and compare as the DUT presents them.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_done;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_done;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic        mem_stall;
  logic        mem_done;

  mem_bus_arbiter #(.MAX_DATA_RUN(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_done(inst_done),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_done(data_done),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata), .mem_stall(mem_stall), .mem_done(mem_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int addr_wait = 0;
  int data_wait = 0;

  bus_cmd_t    exp_bus_q[$];
  logic [31:0] rdata_q[$];
  logic [31:0] exp_inst_q[$];
  logic [31:0] exp_data_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event never or wrongly observed", name);
  endtask

  task automatic expect_bus(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata);
    bus_cmd_t c;
    c.wr = wr; c.size = size; c.addr = addr; c.wdata = wdata;
    exp_bus_q.push_back(c);
    rdata_q.push_back(rdata);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_bus_req"},    32'(bus_req),    32'd0);
    check({tag, "_bus_wr"},     32'(bus_wr),     32'd0);
    check({tag, "_bus_size"},   32'(bus_size),   32'd0);
    check({tag, "_bus_addr"},   bus_addr,        32'd0);
    check({tag, "_bus_wdata"},  bus_wdata,       32'd0);
    check({tag, "_inst_done"},  32'(inst_done),  32'd0);
    check({tag, "_data_done"},  32'(data_done),  32'd0);
    check({tag, "_mem_done"},   32'(mem_done),   32'd0);
    check({tag, "_inst_rdata"}, inst_rdata,      32'd0);
    check({tag, "_data_rdata"}, data_rdata,      32'd0);
  endtask

  task automatic wait_data_done(input string name);
    bit found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (data_done) found = 1;
    end
    if (!found) fail_now(name);
  endtask

  task automatic wait_inst_done(input string name);
    bit found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (inst_done) found = 1;
    end
    if (!found) fail_now(name);
  endtask

  task automatic do_data(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input string name);
    data_wr = wr; data_size = size; data_addr = addr; data_wdata = wdata;
    data_req = 1'b1;
    wait_data_done(name);
    data_req = 1'b0;
  endtask

  task automatic do_inst(input logic [31:0] addr, input string name);
    inst_addr = addr;
    inst_req  = 1'b1;
    wait_inst_done(name);
    inst_req  = 1'b0;
  endtask

  // Bus slave: accepts after addr_wait cycles, responds data_wait cycles later.
  initial begin
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = 32'h0;
    forever begin
      @(negedge clk);
      if (bus_req === 1'b1) begin
        repeat (addr_wait) @(negedge clk);
        bus_addr_ok = 1'b1;
        @(negedge clk);
        bus_addr_ok = 1'b0;
        repeat (data_wait) @(negedge clk);
        if (rdata_q.size() > 0) bus_rdata = rdata_q.pop_front();
        else bus_rdata = 32'h0;
        bus_data_ok = 1'b1;
        @(negedge clk);
        bus_data_ok = 1'b0;
      end
    end
  end

  // Bus monitor: command order on each handshake, field stability while waiting.
  initial begin
    bus_cmd_t cur, prev_cmd, exp;
    logic prev_req, prev_hs;
    prev_req = 1'b0; prev_hs = 1'b0; prev_cmd = '0;
    forever begin
      @(negedge clk); #1;
      cur.wr = bus_wr; cur.size = bus_size; cur.addr = bus_addr; cur.wdata = bus_wdata;
      if (bus_req === 1'b1 && prev_req && !prev_hs) begin
        check("bus_hold_addr", cur.addr, prev_cmd.addr);
        check("bus_hold_ctl", 32'({cur.wr, cur.size}), 32'({prev_cmd.wr, prev_cmd.size}));
      end
      if (bus_req === 1'b1 && bus_addr_ok === 1'b1) begin
        if (exp_bus_q.size() == 0) begin
          fail_now("bus_unexpected_handshake");
        end else begin
          exp = exp_bus_q.pop_front();
          check("bus_addr", cur.addr, exp.addr);
          check("bus_ctl", 32'({cur.wr, cur.size}), 32'({exp.wr, exp.size}));
          check("bus_wdata", cur.wdata, exp.wdata);
        end
      end
      prev_req = bus_req;
      prev_hs  = bus_req & bus_addr_ok;
      prev_cmd = cur;
    end
  end

  // Completion monitor: each done pulse must match the next expected response.
  initial begin
    forever begin
      @(negedge clk); #1;
      if (data_done === 1'b1) begin
        if (exp_data_q.size() == 0) fail_now("data_done_unexpected");
        else check("data_rdata", data_rdata, exp_data_q.pop_front());
        check("mem_done_d", 32'(mem_done), 32'd1);
      end
      if (inst_done === 1'b1) begin
        if (exp_inst_q.size() == 0) fail_now("inst_done_unexpected");
        else check("inst_rdata", inst_rdata, exp_inst_q.pop_front());
        check("mem_done_i", 32'(mem_done), 32'd1);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    rst = 1'b1; flush = 1'b0;
    inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_size = SZ_WORD; data_addr = 32'h0; data_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single load, response two cycles after acceptance; stall until the done cycle.
    addr_wait = 0; data_wait = 1;
    expect_bus(1'b0, SZ_WORD, 32'h1000, 32'h0, 32'hDEADBEEF);
    exp_data_q.push_back(32'hDEADBEEF);
    data_wr = 1'b0; data_size = SZ_WORD; data_addr = 32'h1000; data_wdata = 32'h0;
    data_req = 1'b1;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (data_done) begin
        check("stall_at_done", 32'(mem_stall), 32'd0);
        found = 1;
        data_req = 1'b0;
      end else begin
        check("stall_busy", 32'(mem_stall), 32'd1);
      end
    end
    if (!found) fail_now("load_timeout");
    repeat (2) @(negedge clk);

    // Simultaneous requests: data (byte store) first, then the fetch.
    addr_wait = 0; data_wait = 0;
    expect_bus(1'b1, SZ_BYTE, 32'h5003, 32'h000000AB, 32'h0);
    expect_bus(1'b0, SZ_WORD, 32'h0100, 32'h0, 32'h00000013);
    exp_data_q.push_back(32'h0);
    exp_inst_q.push_back(32'h00000013);
    fork
      do_data(1'b1, SZ_BYTE, 32'h5003, 32'h000000AB, "dual_data_timeout");
      do_inst(32'h0100, "dual_inst_timeout");
    join
    repeat (2) @(negedge clk);

    // Starvation limit: four data grants with the fetch pending, then the fetch, then data.
    // Flush is pulsed only in data done cycles so the fetch cannot sneak in there.
    for (int k = 0; k < 4; k++) begin
      expect_bus(1'b0, SZ_HALF, 32'h3000 + 32'(4 * k), 32'h0, 32'hD0000000 + 32'(k));
      exp_data_q.push_back(32'hD0000000 + 32'(k));
    end
    expect_bus(1'b0, SZ_WORD, 32'h2000, 32'h0, 32'h11112222);
    exp_inst_q.push_back(32'h11112222);
    expect_bus(1'b0, SZ_HALF, 32'h3010, 32'h0, 32'hD0000004);
    exp_data_q.push_back(32'hD0000004);
    fork
      begin
        data_wr = 1'b0; data_size = SZ_HALF; data_addr = 32'h3000; data_wdata = 32'h0;
        data_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
          wait_data_done("run_data_timeout");
          if (k < 4) begin
            data_addr = 32'h3000 + 32'(4 * (k + 1));
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
          end else begin
            data_req = 1'b0;
          end
        end
      end
      do_inst(32'h2000, "run_inst_timeout");
    join
    repeat (2) @(negedge clk);

    // Flush during I_WAIT: bus completes, no inst_done, inst_rdata keeps the old word.
    addr_wait = 0; data_wait = 3;
    expect_bus(1'b0, SZ_WORD, 32'h4000, 32'h0, 32'h12345678);
    inst_addr = 32'h4000; inst_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1; inst_req = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("flush_no_inst_done", 32'(inst_done), 32'd0);
    end
    check("flush_rdata_kept", inst_rdata, 32'h11112222);
    data_wait = 0;
    expect_bus(1'b0, SZ_WORD, 32'h4004, 32'h0, 32'hCAFEF00D);
    exp_inst_q.push_back(32'hCAFEF00D);
    do_inst(32'h4004, "post_flush_timeout");
    repeat (2) @(negedge clk);

    // Acceptance withheld for 10 cycles: request and fields held, no completion.
    addr_wait = 10; data_wait = 0;
    expect_bus(1'b1, SZ_WORD, 32'h6000, 32'h5555AAAA, 32'h0);
    exp_data_q.push_back(32'h0);
    data_wr = 1'b1; data_size = SZ_WORD; data_addr = 32'h6000; data_wdata = 32'h5555AAAA;
    data_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_bus_req", 32'(bus_req), 32'd1);
      check("hold_bus_wdata", bus_wdata, 32'h5555AAAA);
      check("hold_no_done", 32'(data_done), 32'd0);
    end
    wait_data_done("hold_timeout");
    data_req = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in D_WAIT; the late response must be ignored.
    addr_wait = 0; data_wait = 5;
    expect_bus(1'b0, SZ_WORD, 32'h7000, 32'h0, 32'h99999999);
    data_wr = 1'b0; data_size = SZ_WORD; data_addr = 32'h7000; data_wdata = 32'h0;
    data_req = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1; data_req = 1'b0;
    @(negedge clk);
    check_reset_state("midrst");
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_done", 32'(data_done), 32'd0);
    end
    check_reset_state("postrst");

    check("bus_q_drained", 32'(exp_bus_q.size()), 32'd0);
    check("data_q_drained", 32'(exp_data_q.size()), 32'd0);
    check("inst_q_drained", 32'(exp_inst_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
